// File: rtl/alu_seq_param.sv
// Sequential WIDTH-bit ALU (ADD/SUB/MUL/DIV) behind a start/busy/done handshake.
// ADD/SUB finish in one cycle. MUL (shift-add) and DIV (restoring) retire one bit per cycle.
module alu_seq_param #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [1:0]         op,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] result,
  output logic               carry,
  output logic               zero,
  output logic               div_by_zero
);
  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH);

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_SUB = 2'b01,
    OP_MUL = 2'b10,
    OP_DIV = 2'b11
  } op_e;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_e;

  // One restoring step: shift the next dividend bit into the remainder, keep the difference if it fits.
  function automatic logic [2*WIDTH-1:0] div_step(
    input logic [WIDTH-1:0] rem,
    input logic [WIDTH-1:0] quo,
    input logic [WIDTH-1:0] dvsr
  );
    logic [WIDTH:0]   shifted;
    logic [WIDTH-1:0] diff;
    shifted = {rem, quo[WIDTH-1]};
    diff    = shifted[WIDTH-1:0] - dvsr;
    if (shifted >= {1'b0, dvsr}) begin
      div_step = {diff, quo[WIDTH-2:0], 1'b1};
    end else begin
      div_step = {shifted[WIDTH-1:0], quo[WIDTH-2:0], 1'b0};
    end
  endfunction

  state_e               r_state;
  state_e               w_state_nxt;
  op_e                  r_op;
  logic [WIDTH-1:0]     r_a;
  logic [WIDTH-1:0]     r_b;
  logic [CW-1:0]        r_cnt;
  logic [2*WIDTH-1:0]   r_acc;
  logic [2*WIDTH-1:0]   r_mcand;
  logic [WIDTH-1:0]     r_mplier;
  logic [WIDTH-1:0]     r_rem;
  logic [WIDTH-1:0]     r_quo;

  logic                 w_start;
  logic                 w_finish;
  logic                 w_last;
  logic                 w_b_zero;
  logic [WIDTH:0]       w_sum;
  logic [WIDTH:0]       w_diff;
  logic [2*WIDTH-1:0]   w_div_nxt;
  logic [2*WIDTH-1:0]   w_result;
  logic                 w_carry;
  logic                 w_dbz;

  assign w_b_zero  = (r_b == {WIDTH{1'b0}});
  assign w_sum     = {1'b0, r_a} + {1'b0, r_b};
  assign w_diff    = {1'b0, r_a} - {1'b0, r_b};
  assign w_div_nxt = div_step(r_rem, r_quo, r_b);
  // Single-cycle ops and the divide-by-zero exit finish on the first RUN cycle.
  assign w_last    = (r_op == OP_ADD) || (r_op == OP_SUB) ||
                     ((r_op == OP_DIV) && w_b_zero) || (r_cnt == LAST_CNT);

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic and accept/finish strobes
  always_comb begin
    w_state_nxt = r_state;
    w_start     = 1'b0;
    w_finish    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_state_nxt = S_RUN;
          w_start     = 1'b1;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_RUN: begin
        if (w_last) begin
          w_state_nxt = S_IDLE;
          w_finish    = 1'b1;
        end else begin
          w_state_nxt = S_RUN;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Operand capture and the per-cycle MUL/DIV iteration
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_op     <= OP_ADD;
      r_a      <= {WIDTH{1'b0}};
      r_b      <= {WIDTH{1'b0}};
      r_cnt    <= {CW{1'b0}};
      r_acc    <= {(2*WIDTH){1'b0}};
      r_mcand  <= {(2*WIDTH){1'b0}};
      r_mplier <= {WIDTH{1'b0}};
      r_rem    <= {WIDTH{1'b0}};
      r_quo    <= {WIDTH{1'b0}};
    end else if (w_start) begin
      r_op     <= op_e'(op);
      r_a      <= a;
      r_b      <= b;
      r_cnt    <= {CW{1'b0}};
      r_acc    <= {(2*WIDTH){1'b0}};
      r_mcand  <= {{WIDTH{1'b0}}, a};
      r_mplier <= b;
      r_rem    <= {WIDTH{1'b0}};
      r_quo    <= a;
    end else if ((r_state == S_RUN) && !w_last) begin
      r_cnt <= r_cnt + {{(CW-1){1'b0}}, 1'b1};
      if (r_op == OP_MUL) begin
        if (r_mplier[0]) begin
          r_acc <= r_acc + r_mcand;
        end else begin
          r_acc <= r_acc;
        end
        r_mcand  <= {r_mcand[2*WIDTH-2:0], 1'b0};
        r_mplier <= {1'b0, r_mplier[WIDTH-1:1]};
      end else begin
        r_rem <= w_div_nxt[2*WIDTH-1:WIDTH];
        r_quo <= w_div_nxt[WIDTH-1:0];
      end
    end else begin
      r_cnt <= r_cnt;
    end
  end

  // Final result and flags, selected by the captured opcode
  always_comb begin
    w_result = {(2*WIDTH){1'b0}};
    w_carry  = 1'b0;
    w_dbz    = 1'b0;
    case (r_op)
      OP_ADD: begin
        w_result = {{(WIDTH-1){1'b0}}, w_sum};
        w_carry  = w_sum[WIDTH];
      end
      OP_SUB: begin
        w_result = {{WIDTH{1'b0}}, w_diff[WIDTH-1:0]};
        w_carry  = w_diff[WIDTH];
      end
      OP_MUL: begin
        w_result = r_acc;
      end
      OP_DIV: begin
        if (w_b_zero) begin
          w_result = {r_a, {WIDTH{1'b1}}};
          w_dbz    = 1'b1;
        end else begin
          w_result = {r_rem, r_quo};
        end
      end
      default: begin
        w_result = {(2*WIDTH){1'b0}};
      end
    endcase
  end

  // Registered handshake and result outputs; results hold until the next completion
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      busy        <= 1'b0;
      done        <= 1'b0;
      result      <= {(2*WIDTH){1'b0}};
      carry       <= 1'b0;
      zero        <= 1'b0;
      div_by_zero <= 1'b0;
    end else begin
      busy <= (w_state_nxt == S_RUN);
      done <= w_finish;
      if (w_finish) begin
        result      <= w_result;
        carry       <= w_carry;
        zero        <= (w_result == {(2*WIDTH){1'b0}});
        div_by_zero <= w_dbz;
      end else begin
        result      <= result;
      end
    end
  end

endmodule

// File: tb/tb_alu_seq_param.sv
// Scoreboard bench for alu_seq_param: WIDTH=8 and WIDTH=16 instances, directed plus random ops
// checked against an arithmetic reference model.
module tb_alu_seq_param;
  logic clk = 1'b0;
  logic reset = 1'b1;

  logic       start8, busy8, done8, carry8, zero8, dbz8;
  logic [1:0] op8;
  logic [7:0] a8, b8;
  logic [15:0] res8;

  logic        start16, busy16, done16, carry16, zero16, dbz16;
  logic [1:0]  op16;
  logic [15:0] a16, b16;
  logic [31:0] res16;

  int errors = 0;
  int checks = 0;
  longint unsigned cyc = 0;

  typedef struct {
    logic [31:0]     res;
    logic            carry;
    logic            zero;
    logic            dbz;
    int              lat;
    longint unsigned due;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  int run_q[2];
  int n_done[2];

  alu_seq_param #(.WIDTH(8)) dut8 (
    .clk(clk), .reset(reset), .start(start8), .op(op8), .a(a8), .b(b8),
    .busy(busy8), .done(done8), .result(res8), .carry(carry8), .zero(zero8),
    .div_by_zero(dbz8)
  );

  alu_seq_param #(.WIDTH(16)) dut16 (
    .clk(clk), .reset(reset), .start(start16), .op(op16), .a(a16), .b(b16),
    .busy(busy16), .done(done16), .result(res16), .carry(carry16), .zero(zero16),
    .div_by_zero(dbz16)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 64'd1;

  // Reference: plain arithmetic on the operands, independent of any iteration scheme.
  function automatic exp_t model(int w, logic [1:0] o, logic [15:0] x, logic [15:0] y);
    exp_t m;
    longint unsigned ua, ub, mask, r;
    mask = (64'd1 << w) - 64'd1;
    ua = 64'(x) & mask;
    ub = 64'(y) & mask;
    m.carry = 1'b0;
    m.dbz = 1'b0;
    m.lat = 1;
    m.due = 0;
    r = 0;
    case (o)
      2'd0: begin r = ua + ub; m.carry = (r >= (64'd1 << w)); end
      2'd1: begin r = (ua - ub) & mask; m.carry = (ua < ub); end
      2'd2: begin r = ua * ub; m.lat = w + 1; end
      default: begin
        if (ub == 0) begin r = (ua << w) | mask; m.dbz = 1'b1; end
        else begin r = ((ua % ub) << w) | (ua / ub); m.lat = w + 1; end
      end
    endcase
    m.res = 32'(r);
    m.zero = (r == 0);
    return m;
  endfunction

  task automatic chk(int k, string name, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL inst%0d %s: got %0h expected %0h (cycle %0d)", k, name, got, exp, cyc);
    end
  endtask

  task automatic mon(int k, logic bz, logic dn, logic [31:0] r, logic c, logic z, logic d);
    exp_t e;
    if (bz) run_q[k]++;
    if (dn) begin
      n_done[k]++;
      if ((k == 0 && q0.size() == 0) || (k == 1 && q1.size() == 0)) begin
        checks++;
        errors++;
        $display("FAIL inst%0d unexpected_done: got done=1 expected no pending op (cycle %0d)", k, cyc);
      end else begin
        if (k == 0) e = q0.pop_front();
        else e = q1.pop_front();
        chk(k, "result", r, e.res);
        chk(k, "carry", 32'(c), 32'(e.carry));
        chk(k, "zero", 32'(z), 32'(e.zero));
        chk(k, "div_by_zero", 32'(d), 32'(e.dbz));
        chk(k, "done_cycle", 32'(cyc), 32'(e.due));
        chk(k, "busy_cycles", 32'(run_q[k]), 32'(e.lat));
      end
      run_q[k] = 0;
    end
  endtask

  // Monitor: pops the scoreboard whenever an instance pulses done.
  always @(negedge clk) begin
    if (reset) begin
      run_q[0] = 0;
      run_q[1] = 0;
    end else begin
      mon(0, busy8, done8, {16'd0, res8}, carry8, zero8, dbz8);
      mon(1, busy16, done16, res16, carry16, zero16, dbz16);
    end
  end

  task automatic drive(int k, logic s, logic [1:0] o, logic [15:0] x, logic [15:0] y);
    if (k == 0) begin start8 = s; op8 = o; a8 = x[7:0]; b8 = y[7:0]; end
    else begin start16 = s; op16 = o; a16 = x; b16 = y; end
  endtask

  task automatic set_start(int k, logic s);
    if (k == 0) start8 = s;
    else start16 = s;
  endtask

  function automatic logic get_busy(int k);
    return (k == 0) ? busy8 : busy16;
  endfunction

  function automatic int qsize(int k);
    return (k == 0) ? q0.size() : q1.size();
  endfunction

  // Called on a negedge with the instance idle (or in its done cycle).
  task automatic issue(int k, logic [1:0] o, logic [15:0] x, logic [15:0] y);
    exp_t e;
    e = model((k == 0) ? 8 : 16, o, x, y);
    e.due = cyc + 64'd1 + longint'(e.lat);
    drive(k, 1'b1, o, x, y);
    if (k == 0) q0.push_back(e);
    else q1.push_back(e);
  endtask

  // Waits until busy drops; with scramble, inputs (including start) churn while busy.
  task automatic run_op(int k, bit scramble);
    int guard = 0;
    @(negedge clk);
    set_start(k, 1'b0);
    while (get_busy(k) && guard < 100) begin
      if (scramble) drive(k, 1'($urandom), 2'($urandom), 16'($urandom), 16'($urandom));
      @(negedge clk);
      guard++;
    end
    if (guard >= 100) begin
      checks++;
      errors++;
      $display("FAIL inst%0d busy_timeout: got busy=1 after %0d cycles expected busy=0", k, guard);
    end
    set_start(k, 1'b0);
  endtask

  task automatic drain(int k);
    int guard = 0;
    set_start(k, 1'b0);
    while ((qsize(k) != 0 || get_busy(k)) && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 100) begin
      checks++;
      errors++;
      $display("FAIL inst%0d drain_timeout: got %0d pending expected 0", k, qsize(k));
    end
  endtask

  task automatic random_ops(int k, int n);
    logic [15:0] x, y;
    for (int i = 0; i < n; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        set_start(k, 1'b0);
        repeat ($urandom_range(1, 3)) @(negedge clk);
      end
      x = 16'($urandom);
      y = ($urandom_range(0, 5) == 0) ? 16'd0 : 16'($urandom);
      issue(k, 2'($urandom_range(0, 3)), x, y);
      run_op(k, 1'($urandom));
    end
  endtask

  initial begin
    drive(0, 1'b0, 2'd0, 16'd0, 16'd0);
    drive(1, 1'b0, 2'd0, 16'd0, 16'd0);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    chk(0, "reset_busy", 32'(busy8), 32'd0);
    chk(0, "reset_done", 32'(done8), 32'd0);
    chk(0, "reset_result", {16'd0, res8}, 32'd0);
    chk(1, "reset_result", res16, 32'd0);
    chk(1, "reset_flags", {29'd0, carry16, zero16, dbz16}, 32'd0);
    reset = 1'b0;
    @(negedge clk);

    issue(0, 2'd0, 16'd200, 16'd100); run_op(0, 1'b0);
    issue(0, 2'd1, 16'd5, 16'd7);     run_op(0, 1'b0);
    issue(0, 2'd1, 16'd9, 16'd9);     run_op(0, 1'b0);
    issue(0, 2'd2, 16'd255, 16'd255); run_op(0, 1'b1);
    issue(0, 2'd3, 16'd200, 16'd7);   run_op(0, 1'b1);
    issue(0, 2'd0, 16'd17, 16'd3);    run_op(0, 1'b0);
    issue(0, 2'd1, 16'd3, 16'd17);    run_op(0, 1'b0);
    issue(0, 2'd3, 16'd13, 16'd0);    run_op(0, 1'b0);

    // Abort a multiply partway; nothing may complete afterwards.
    begin
      int nd;
      issue(0, 2'd2, 16'd3, 16'd5);
      @(negedge clk);
      set_start(0, 1'b0);
      repeat (3) @(negedge clk);
      reset = 1'b1;
      #1;
      chk(0, "abort_busy", 32'(busy8), 32'd0);
      chk(0, "abort_result", {16'd0, res8}, 32'd0);
      chk(0, "abort_flags", {29'd0, carry8, zero8, dbz8}, 32'd0);
      q0.delete();
      q1.delete();
      repeat (2) @(negedge clk);
      reset = 1'b0;
      nd = n_done[0];
      repeat (15) @(negedge clk);
      chk(0, "no_done_after_abort", 32'(n_done[0]), 32'(nd));
    end

    random_ops(0, 60);
    drain(0);

    issue(1, 2'd2, 16'hFFFF, 16'hFFFF); run_op(1, 1'b1);
    issue(1, 2'd3, 16'hFFFF, 16'h0100); run_op(1, 1'b0);
    issue(1, 2'd3, 16'h1234, 16'h0000); run_op(1, 1'b0);
    random_ops(1, 25);
    drain(1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: got simulation still running expected finish");
    $fatal(1, "watchdog expired");
  end
endmodule
